adaptive_binarizer: RTL
=======================

Name: adaptive_binarizer

Overview:
Parametrised streaming gray-to-binary converter for the camera pixel pipeline. It sits between the grayscale stage and the frame-buffer writer.
Supports four modes: fixed threshold, inverted fixed, per-line hysteresis, and adaptive.
In adaptive mode the threshold is the previous frame's mean intensity plus a signed offset. The mean comes from a per-frame accumulator and an iterative divider that runs during vertical blank.

Parameters:
DW, 12, pixel data width
CNT_W, 20, pixel-counter width (max 2^CNT_W-1 pixels per frame)
DEF_TH, 2547, threshold used after reset until the first adaptive result exists

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-low
iFVAL  in  1  frame valid; high for the whole frame
iDVAL  in  1  pixel valid
iDATA  in  DW  grayscale pixel
iMODE  in  2  0 fixed, 1 hysteresis, 2 adaptive, 3 inverted fixed
iTH_HI  in  DW  fixed threshold / hysteresis upper threshold
iTH_LO  in  DW  hysteresis lower threshold
iOFFSET  in  DW+1  signed two's-complement offset added to the frame mean
oDVAL  out  1  registered iDVAL
oDATA  out  DW  all-ones or zero
oTHRESH  out  DW  current adaptive threshold register
oBUSY  out  1  divider running

Behaviour:
- Reset (async, iRST low):
  - oDVAL=0, oDATA=0, oTHRESH=DEF_TH, oBUSY=0.
  - Accumulators, divider, hysteresis state and the frame-latched mode/threshold are cleared; latched threshold = DEF_TH, latched mode = 0.
  - Reset mid-division aborts the division; oTHRESH returns to DEF_TH.
- Pipeline:
  - Latency 1 cycle; oDVAL <= iDVAL every cycle.
  - oDATA is updated every cycle. When iDVAL=0 it takes value 0.
- Frame latch: on the rising edge of iFVAL (registered iFVAL low, iFVAL high), iMODE and the effective adaptive threshold are captured. They hold for the whole frame, so mid-frame changes of iMODE or oTHRESH have no effect until the next frame.
- Mode 0: oDATA = (iDATA > iTH_HI) ? all-ones : 0.
- Mode 3: oDATA = (iDATA > iTH_HI) ? 0 : all-ones.
- Mode 1 (hysteresis):
  - A pixel is high if iDATA > iTH_HI, or if the previous valid output in the same line was high and iDATA > iTH_LO.
  - State is cleared on any cycle with iDVAL=0, i.e. at line end.
  - iTH_LO > iTH_HI degenerates to mode 0 behaviour.
- Mode 2: oDATA = (iDATA > latched threshold) ? all-ones : 0.
- Accumulation (all modes):
  - While iFVAL&iDVAL: sum += iDATA (width DW+CNT_W) and count += 1.
  - When count reaches 2^CNT_W-1, both sum and count freeze for the rest of the frame.
- Frame end (registered iFVAL high, iFVAL low):
  - sum and count are snapshotted into the divider; the accumulators clear in the same cycle.
  - If count=0, no division runs and oTHRESH is unchanged.
  - Otherwise oBUSY=1 from the next cycle.
- Divider:
  - Restoring, 1 quotient bit per cycle, DW+CNT_W iterations.
  - When done, oTHRESH = clamp(quotient + iOFFSET, 0, 2^DW-1), with iOFFSET sampled at completion; oBUSY=0.
  - oTHRESH updates exactly DW+CNT_W+1 cycles after the frame-end detect edge; 33 cycles at defaults.
- Simultaneous events:
  - A frame end while busy aborts the running division and restarts it with the new snapshot.
  - If busy at a frame start, the frame latches the old oTHRESH.

Test Plan:
- Mode 0, iTH_HI=2547, pixels 2547, 2548, 0, 4095 -> oDATA 0, 4095, 0, 4095, each one cycle later; oDVAL follows iDVAL delayed by 1.
- Mode 1, TH_HI=3000, TH_LO=1000, line 500, 3100, 1500, 900, 1500 -> 0, 4095, 4095, 0, 0. With iDVAL low for one cycle before the 1500 following the 3100, that 1500 -> 0.
- Mode 2, iOFFSET=0: frame of 16 pixels all 1024 -> oBUSY high, then oTHRESH=1024 exactly 33 cycles after frame end. Next frame, pixels 1024/1025 -> 0/4095. With iOFFSET=-2000 -> oTHRESH=0; with iOFFSET=+4000 on mean 1024 -> 4095 (saturated).
- Frame with iFVAL high but no iDVAL -> oBUSY stays 0, oTHRESH unchanged.
- Assert iRST low 10 cycles into a division -> all outputs at reset values immediately; oTHRESH=2547 after release.
- Change iMODE 0->3 mid-frame -> output polarity unchanged until the next iFVAL rise, then inverted.

Source files
------------

// File: rtl/adaptive_binarizer.sv
// Streaming gray-to-binary converter with fixed, inverted, hysteresis and adaptive
// (previous-frame mean plus offset) thresholding; the mean divider runs during vertical blank.
module adaptive_binarizer #(
    parameter int DW     = 12,
    parameter int CNT_W  = 20,
    parameter int DEF_TH = 2547
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iFVAL,
    input  logic          iDVAL,
    input  logic [DW-1:0] iDATA,
    input  logic [1:0]    iMODE,
    input  logic [DW-1:0] iTH_HI,
    input  logic [DW-1:0] iTH_LO,
    input  logic [DW:0]   iOFFSET,
    output logic          oDVAL,
    output logic [DW-1:0] oDATA,
    output logic [DW-1:0] oTHRESH,
    output logic          oBUSY
);

    localparam int SW  = DW + CNT_W;
    localparam int AW  = SW + 2;
    localparam int ITW = $clog2(SW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [DW-1:0]    DEF_TH_V  = DW'(DEF_TH);
    localparam logic [ITW-1:0]   LAST_ITER = ITW'(SW - 1);

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_HYST  = 2'd1,
        MODE_ADAPT = 2'd2,
        MODE_INV   = 2'd3
    } modeType;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } divState;

    logic             fvalR;
    logic             frameStart;
    logic             frameEnd;
    modeType          modeL;
    modeType          effMode;
    logic [DW-1:0]    thL;
    logic [DW-1:0]    effTh;
    logic             prevOn;
    logic             pixOn;

    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt;
    logic             divLoad;

    divState          state;
    divState          stateNext;
    logic [SW-1:0]    quot;
    logic [CNT_W-1:0] divisor;
    logic [CNT_W-1:0] rem;
    logic [ITW-1:0]   iter;
    logic [CNT_W:0]   remShift;
    logic [CNT_W:0]   remDiff;
    logic             remGe;
    logic [AW-1:0]    adjSum;
    logic [DW-1:0]    clampVal;
    logic [DW-1:0]    thresh;

    assign frameStart = iFVAL & ~fvalR;
    assign frameEnd   = fvalR & ~iFVAL;
    assign divLoad    = frameEnd && (cnt != '0);

    // The frame-start cycle itself already uses the values being captured.
    assign effMode = frameStart ? modeType'(iMODE) : modeL;
    assign effTh   = frameStart ? thresh : thL;

    always_comb begin
        pixOn = 1'b0;
        case (effMode)
            MODE_FIXED: pixOn = iDATA > iTH_HI;
            MODE_HYST:  pixOn = (iDATA > iTH_HI) || (prevOn && (iDATA > iTH_LO));
            MODE_ADAPT: pixOn = iDATA > effTh;
            MODE_INV:   pixOn = !(iDATA > iTH_HI);
            default:    pixOn = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fvalR  <= 1'b0;
            modeL  <= MODE_FIXED;
            thL    <= DEF_TH_V;
            prevOn <= 1'b0;
            oDVAL  <= 1'b0;
            oDATA  <= '0;
        end else begin
            fvalR  <= iFVAL;
            if (frameStart) begin
                modeL <= modeType'(iMODE);
                thL   <= thresh;
            end
            prevOn <= iDVAL & pixOn;
            oDVAL  <= iDVAL;
            oDATA  <= (iDVAL && pixOn) ? '1 : '0;
        end
    end

    // Accumulators saturate by freezing once the pixel count is full.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            sum <= '0;
            cnt <= '0;
        end else if (frameEnd) begin
            sum <= '0;
            cnt <= '0;
        end else if (iFVAL && iDVAL && (cnt != CNT_MAX)) begin
            sum <= sum + SW'(iDATA);
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= DIV_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (divLoad) begin
            stateNext = DIV_RUN;
        end else begin
            case (state)
                DIV_RUN:  if (iter == LAST_ITER) stateNext = DIV_DONE;
                DIV_DONE: stateNext = DIV_IDLE;
                default:  stateNext = state;
            endcase
        end
    end

    assign remShift = {rem, quot[SW-1]};
    assign remDiff  = remShift - {1'b0, divisor};
    assign remGe    = remShift >= {1'b0, divisor};
    assign adjSum   = {2'b00, quot} + {{(AW-DW-1){iOFFSET[DW]}}, iOFFSET};

    always_comb begin
        clampVal = adjSum[DW-1:0];
        if (adjSum[AW-1]) begin
            clampVal = '0;
        end else if (|adjSum[AW-2:DW]) begin
            clampVal = '1;
        end
    end

    // Quotient bits shift into the dividend register, one per cycle, MSB first.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            quot    <= '0;
            divisor <= '0;
            rem     <= '0;
            iter    <= '0;
            thresh  <= DEF_TH_V;
        end else begin
            if (divLoad) begin
                quot    <= sum;
                divisor <= cnt;
                rem     <= '0;
                iter    <= '0;
            end else if (state == DIV_RUN) begin
                quot <= {quot[SW-2:0], remGe};
                rem  <= remGe ? remDiff[CNT_W-1:0] : remShift[CNT_W-1:0];
                iter <= iter + ITW'(1);
            end
            if (state == DIV_DONE) begin
                thresh <= clampVal;
            end
        end
    end

    assign oTHRESH = thresh;
    assign oBUSY   = (state != DIV_IDLE);

endmodule
